up_down_counter_mod: RTL and testbench
======================================

// Module: up_down_counter_mod
// PURPOSE
//  Parametrised, registered modulo-N up/down counter; next generation of the 3-bit
//  up/down state counter. Adds count enable, synchronous parallel load, arbitrary
//  modulus and a terminal-count pulse. Used as a step/position counter feeding
//  display and sequencing logic; all outputs are registered.
// PARAMETERS
//  WIDTH      3            counter width in bits (>=1)
//  MAX_VAL    2**WIDTH-1   highest count value; modulus = MAX_VAL+1; MAX_VAL < 2**WIDTH
//  RESET_VAL  0            value loaded into q on reset; RESET_VAL <= MAX_VAL
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  en        in   1      count enable; 1 = step this cycle
//  u_d       in   1      direction; 1 = up, 0 = down
//  load      in   1      synchronous load strobe; priority over en
//  load_val  in   WIDTH  value taken on load
//  q         out  WIDTH  current count, registered
//  tc        out  1      terminal-count pulse, registered, one cycle per boundary event
//  at_zero   out  1      registered, 1 when q == 0
//  at_max    out  1      registered, 1 when q == MAX_VAL
// BEHAVIOUR
//  - One clock, clk. rst is asynchronous and active-high: on rst=1, immediately
//    q=RESET_VAL, tc=0, at_zero=(RESET_VAL==0), at_max=(RESET_VAL==MAX_VAL).
//    Reset mid-count discards the step in progress; first step on the first rising
//    clk edge after rst deasserts.
//  - Per rising edge, priority: load > en > hold.
//    load=1: q <= (load_val > MAX_VAL) ? MAX_VAL : load_val (clamp); tc <= 0; en, u_d ignored.
//    en=1, u_d=1: q==MAX_VAL -> boundary event; else q <= q+1, tc <= 0.
//    en=1, u_d=0: q==0       -> boundary event; else q <= q-1, tc <= 0.
//    en=0, load=0: q holds; tc <= 0.
//  - Boundary event (wrap mode, default): up wraps MAX_VAL->0, down wraps 0->MAX_VAL;
//    tc <= 1 for exactly that one cycle.
//  - Latency: q, tc, at_zero, at_max all update on the same edge; 1 cycle from
//    en/load to output. at_zero/at_max always agree with q in the same cycle.
//  - tc stays high for consecutive cycles only if consecutive boundary events occur
//    (e.g. saturate mode held at bound, or MAX_VAL==0).
//  - MAX_VAL==0: every enabled step is a boundary event; q stays 0.
//  - Arithmetic width is WIDTH bits; no compare/add overflows beyond WIDTH since q
//    never exceeds MAX_VAL. Direction change takes effect on the next edge, no bubble.
//  - Parameter check: MAX_VAL >= 2**WIDTH or RESET_VAL > MAX_VAL -> simulation
//    prints an error and calls $finish at time 0.
// CONFIGURATION
//  UDC_SATURATE_EN (macro)
//   defined:   boundary event saturates instead of wrapping: up at MAX_VAL holds
//              MAX_VAL, down at 0 holds 0; tc <= 1 each cycle a step is blocked.
//   undefined: wrap behaviour as above. Ports and all other behaviour identical.
// TESTING  (WIDTH=3, MAX_VAL=5, RESET_VAL=0 unless noted)
//  1 rst=1 mid-count at q=3, asynchronous to clk -> q=0, tc=0, at_zero=1 before next edge.
//  2 en=1,u_d=1 for 7 edges from 0 -> q: 1,2,3,4,5,0,1; tc=1 only on the edge giving 0;
//    at_max=1 only while q=5.
//  3 en=1,u_d=0 from 0 for 2 edges -> q: 5,4; tc=1 on first edge; with UDC_SATURATE_EN
//    -> q: 0,0, tc=1 both edges.
//  4 load=1,load_val=7 with en=1 -> q=5 (clamped), tc=0; then load_val=2 -> q=2.
//  5 en=0 with u_d toggling 10 cycles at q=4 -> q stays 4, tc=0 throughout.
//  6 RESET_VAL=3: reset -> q=3, at_zero=0, at_max=0; one up step -> q=4.

Source files
------------

// File: rtl/up_down_counter_mod.sv
// Registered modulo-N up/down counter with enable, clamped parallel load and terminal-count pulse.
// Optional build macro UDC_SATURATE_EN: boundary steps saturate at 0/MAX_VAL instead of wrapping.
module up_down_counter_mod #(
  parameter int WIDTH     = 3,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             u_d,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_zero,
  output logic             at_max
);

  generate
    if (WIDTH < 1 || MAX_VAL < 0 || MAX_VAL >= 2**WIDTH || RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_param_err
      $fatal(1, "up_down_counter_mod: illegal parameters WIDTH=%0d MAX_VAL=%0d RESET_VAL=%0d",
             WIDTH, MAX_VAL, RESET_VAL);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_Q  = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_Q  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_Q = '0;
  localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

`ifdef UDC_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  // Loaded values above the modulus are pinned to the top count.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  // Value taken on a blocked step: stay put when saturating, otherwise wrap around.
  function automatic logic [WIDTH-1:0] bound_val(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] wrap_to);
    return SATURATE ? cur : wrap_to;
  endfunction

  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

  always_comb begin
    q_nxt  = q;
    tc_nxt = 1'b0;
    if (load) begin
      q_nxt = clamp_load(load_val);
    end else if (en) begin
      if (u_d) begin
        if (q == MAX_Q) begin
          tc_nxt = 1'b1;
          q_nxt  = bound_val(q, ZERO_Q);
        end else begin
          q_nxt = q + ONE_Q;
        end
      end else begin
        if (q == ZERO_Q) begin
          tc_nxt = 1'b1;
          q_nxt  = bound_val(q, MAX_Q);
        end else begin
          q_nxt = q - ONE_Q;
        end
      end
    end
  end

  // Output register stage: flags are decoded from q_nxt so they track q on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= RST_Q;
      tc      <= 1'b0;
      at_zero <= (RST_Q == ZERO_Q);
      at_max  <= (RST_Q == MAX_Q);
    end else begin
      q       <= q_nxt;
      tc      <= tc_nxt;
      at_zero <= (q_nxt == ZERO_Q);
      at_max  <= (q_nxt == MAX_Q);
    end
  end

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Self-checking bench for up_down_counter_mod (WIDTH=3, MAX_VAL=5; RESET_VAL=0 and RESET_VAL=3 instances).
module tb_up_down_counter_mod;

  localparam int MAXV = 5;
  localparam int MOD  = MAXV + 1;
`ifdef UDC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, u_d, load;
  logic [2:0] load_val;
  logic [2:0] q, q2;
  logic       tc, at_zero, at_max, tc2, at_zero2, at_max2;

  int vectors = 0;
  int errors  = 0;
  int m_q, m2_q;
  bit m_tc, m2_tc;

  up_down_counter_mod #(.WIDTH(3), .MAX_VAL(5), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .u_d(u_d), .load(load), .load_val(load_val),
    .q(q), .tc(tc), .at_zero(at_zero), .at_max(at_max));

  up_down_counter_mod #(.WIDTH(3), .MAX_VAL(5), .RESET_VAL(3)) dut_r3 (
    .clk(clk), .rst(rst), .en(en), .u_d(u_d), .load(load), .load_val(load_val),
    .q(q2), .tc(tc2), .at_zero(at_zero2), .at_max(at_max2));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: counting modulo MOD, boundary when the arithmetic result leaves [0, MAXV].
  function automatic void ref_next(input int cur, input bit ld, input int lv, input bit e,
                                   input bit ud, output int nq, output bit ntc);
    int raw;
    nq  = cur;
    ntc = 1'b0;
    if (ld) begin
      nq = (lv > MAXV) ? MAXV : lv;
    end else if (e) begin
      raw = ud ? cur + 1 : cur - 1;
      ntc = (raw < 0) || (raw > MAXV);
      if (SAT) nq = (raw < 0) ? 0 : ((raw > MAXV) ? MAXV : raw);
      else     nq = (raw + MOD) % MOD;
    end
  endfunction

  function automatic logic [5:0] exp_vec(input int mq, input bit mtc);
    logic [2:0] qv;
    qv = mq[2:0];
    return {qv, mtc, (mq == 0), (mq == MAXV)};
  endfunction

  task automatic step();
    int nq;
    bit ntc;
    @(posedge clk);
    ref_next(m_q, load, int'(load_val), en, u_d, nq, ntc);
    m_q = nq; m_tc = ntc;
    ref_next(m2_q, load, int'(load_val), en, u_d, nq, ntc);
    m2_q = nq; m2_tc = ntc;
    #1;
  endtask

  task automatic drive(input bit ld, input int lv, input bit e, input bit ud);
    load = ld; load_val = lv[2:0]; en = e; u_d = ud;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    m_q = 0; m_tc = 0; m2_q = 3; m2_tc = 0;
    #1;
    vectors++;
    if ({q, tc, at_zero, at_max} !== 6'b000_0_1_0) begin
      errors++;
      $display("FAIL reset_state: got q=%0d tc=%b z=%b m=%b, required q=0 tc=0 z=1 m=0", q, tc, at_zero, at_max);
    end
    vectors++;
    if ({q2, tc2, at_zero2, at_max2} !== 6'b011_0_0_0) begin
      errors++;
      $display("FAIL reset_val3: got q=%0d tc=%b z=%b m=%b, required q=3 tc=0 z=0 m=0", q2, tc2, at_zero2, at_max2);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 1, 1);
    step();
    vectors++;
    if (q2 !== 3'd4 || q !== 3'd1) begin
      errors++;
      $display("FAIL first_step: got q=%0d q2=%0d, required q=1 q2=4", q, q2);
    end
  endtask

  task automatic test_wrap_up();
    int eq[7], et[7];
`ifdef UDC_SATURATE_EN
    eq = '{1, 2, 3, 4, 5, 5, 5}; et = '{0, 0, 0, 0, 0, 1, 1};
`else
    eq = '{1, 2, 3, 4, 5, 0, 1}; et = '{0, 0, 0, 0, 0, 1, 0};
`endif
    drive(1, 0, 0, 0);
    step();
    drive(0, 0, 1, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      vectors++;
      if ({q, tc, at_zero, at_max} !== exp_vec(eq[i], et[i][0])) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got q=%0d tc=%b z=%b m=%b, required q=%0d tc=%0d", i, q, tc, at_zero, at_max, eq[i], et[i]);
      end
    end
  endtask

  task automatic test_wrap_down();
    int eq[2], et[2];
`ifdef UDC_SATURATE_EN
    eq = '{0, 0}; et = '{1, 1};
`else
    eq = '{5, 4}; et = '{1, 0};
`endif
    drive(1, 0, 0, 0);
    step();
    drive(0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({q, tc, at_zero, at_max} !== exp_vec(eq[i], et[i][0])) begin
        errors++;
        $display("FAIL wrap_down[%0d]: got q=%0d tc=%b z=%b m=%b, required q=%0d tc=%0d", i, q, tc, at_zero, at_max, eq[i], et[i]);
      end
    end
  endtask

  task automatic test_load_clamp();
    drive(1, 7, 1, 1);
    step();
    vectors++;
    if ({q, tc, at_zero, at_max} !== 6'b101_0_0_1) begin
      errors++;
      $display("FAIL load_clamp: got q=%0d tc=%b z=%b m=%b, required q=5 tc=0 z=0 m=1", q, tc, at_zero, at_max);
    end
    drive(1, 2, 1, 0);
    step();
    vectors++;
    if ({q, tc, at_zero, at_max} !== 6'b010_0_0_0) begin
      errors++;
      $display("FAIL load_2: got q=%0d tc=%b z=%b m=%b, required q=2 tc=0 z=0 m=0", q, tc, at_zero, at_max);
    end
  endtask

  task automatic test_hold();
    drive(1, 4, 0, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(0, $urandom_range(0, 7), 0, i[0]);
      step();
      vectors++;
      if (q !== 3'd4 || tc !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got q=%0d tc=%b, required q=4 tc=0", i, q, tc);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 3, 0, 0);
    step();
    vectors++;
    if (q !== 3'd3) begin
      errors++;
      $display("FAIL preload3: got q=%0d, required 3", q);
    end
    drive(0, 0, 1, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    m_q = 0; m_tc = 0; m2_q = 3; m2_tc = 0;
    #1;
    vectors++;
    if ({q, tc, at_zero, at_max} !== 6'b000_0_1_0) begin
      errors++;
      $display("FAIL async_reset: got q=%0d tc=%b z=%b m=%b, required q=0 tc=0 z=1 m=0", q, tc, at_zero, at_max);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    vectors++;
    if (q !== 3'd0 || q2 !== 3'd3) begin
      errors++;
      $display("FAIL reset_hold: got q=%0d q2=%0d, required q=0 q2=3", q, q2);
    end
    step();
    vectors++;
    if (q !== 3'd1 || q2 !== 3'd4) begin
      errors++;
      $display("FAIL post_reset_step: got q=%0d q2=%0d, required q=1 q2=4", q, q2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 1));
      step();
      vectors++;
      if ({q, tc, at_zero, at_max} !== exp_vec(m_q, m_tc)) begin
        errors++;
        $display("FAIL random[%0d]: got q=%0d tc=%b z=%b m=%b, required q=%0d tc=%0d", i, q, tc, at_zero, at_max, m_q, m_tc);
      end
      vectors++;
      if ({q2, tc2, at_zero2, at_max2} !== exp_vec(m2_q, m2_tc)) begin
        errors++;
        $display("FAIL random_r3[%0d]: got q=%0d tc=%b z=%b m=%b, required q=%0d tc=%0d", i, q2, tc2, at_zero2, at_max2, m2_q, m2_tc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_load_clamp();
    test_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
